// File: rtl/inst_fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package inst_fetch_pkg;

    localparam int unsigned ADDR_W_DEF   = 8;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int unsigned INST_W       = 32;
    localparam logic [31:0] PC_STEP      = 32'd4;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/inst_fetch_queue.sv
// Prefetch FIFO of {pc, inst} with synchronous flush and push/pop-when-full support.
module fetch_queue
    import inst_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [31:0]       push_pc,
    input  logic [INST_W-1:0] push_inst,
    output logic              valid,
    output logic              full,
    output logic [31:0]       head_pc,
    output logic [INST_W-1:0] head_inst
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W:0]   count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; empty entries are masked at the head.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= '{pc: push_pc, inst: push_inst};
        end
    end

    always_comb begin
        valid     = (count_q != '0);
        full      = (count_q == FULL_CNT);
        head_pc   = '0;
        head_inst = '0;
        if (valid) begin
            head_pc   = mem_q[rd_ptr_q].pc;
            head_inst = mem_q[rd_ptr_q].inst;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Fetch front end: owns the PC, drives imem, buffers words for decode, handles redirects.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_inst,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [31:0]       out_pc
);

    logic [31:0] fetch_pc_q;
    logic        q_full;
    logic        push;
    logic        pop;

    assign pop       = out_valid && out_ready;
    // A pop frees a slot this cycle, so a full queue can still accept the next word.
    assign push      = !redirect_valid && (!q_full || pop);
    assign imem_addr = fetch_pc_q[ADDR_W+1:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= word_align(RESET_PC);
        end else if (redirect_valid) begin
            fetch_pc_q <= word_align(redirect_pc);
        end else if (push) begin
            fetch_pc_q <= fetch_pc_q + PC_STEP;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_fetch_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .pop       (pop),
        .push_pc   (fetch_pc_q),
        .push_inst (imem_inst),
        .valid     (out_valid),
        .full      (q_full),
        .head_pc   (out_pc),
        .head_inst (out_inst)
    );

endmodule
